mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Arbitrates the single unified memory bus port between the instruction-fetch stage and the memory-stage load/store unit. It sequences one outstanding bus transaction at a time and returns registered read data with a one-cycle ready pulse. It drives `stall_f` and `stall_m` into the pipeline hazard logic alongside the load-use stall path. Data accesses take priority over fetches, with a fairness rule that prevents fetch starvation.

## Interface
- `ADDR_W`, 32: bus and requester address width.
- `DATA_W`, 32: bus data width; byte-enable width is `DATA_W/8`.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch wants an instruction at `if_addr`.
- `if_addr`  in  ADDR_W  fetch address.
- `flush`  in  1  branch/jump redirect; the in-flight fetch is discarded.
- `if_rdata`  out  DATA_W  fetched word; valid while `if_ready`.
- `if_ready`  out  1  one-cycle fetch completion pulse.
- `dm_access`  in  `memaccess_t`  `MEM_READ` or `MEM_WRITE` request; any other value means no access.
- `dm_addr`  in  ADDR_W  data address.
- `dm_wdata`  in  DATA_W  store data.
- `dm_be`  in  DATA_W/8  store byte enables.
- `dm_rdata`  out  DATA_W  load data; valid while `dm_ready`.
- `dm_ready`  out  1  one-cycle data completion pulse.
- `bus_req`  out  1  bus request.
- `bus_we`, `bus_addr`, `bus_wdata`, `bus_be`  out  bus request fields.
- `bus_gnt`  in  1  request accepted.
- `bus_rvalid`  in  1  response; for writes it is the acknowledge.
- `bus_rdata`  in  DATA_W  response data.
- `stall_f`, `stall_m`  out  1  hold the fetch and memory stages.

## Operation
- FSM states: `IDLE`, `D_REQ`, `D_WAIT`, `I_REQ`, `I_WAIT`.
- `IDLE` with a data request goes to `D_REQ`; with only `if_req` it goes to `I_REQ`.
- Both pending in `IDLE`: data wins, unless the last served transaction was data and `if_req` is pending, in which case fetch wins. A `last_data` bit tracks the last served transaction.
- `*_REQ`: `bus_req=1`; `bus_addr`, `bus_we`, `bus_wdata` and `bus_be` are registered and must stay stable until `bus_gnt`. On `bus_gnt` the FSM moves to `*_WAIT` and `bus_req` drops.
- `*_WAIT` on `bus_rvalid`: capture `bus_rdata` into the matching rdata register, pulse the matching ready next cycle, return to `IDLE`.
- Fetch requests always use `bus_we=0` and `bus_be` all ones.
- `flush` during `I_REQ` or `I_WAIT` sets `drop`. The transaction still completes on the bus, but `if_ready` is suppressed and `drop` clears on return to `IDLE`.
- `flush` in `IDLE` has no effect. `flush` never affects data transactions.
- `stall_f = if_req & ~if_ready`.
- `stall_m = dm_access_active & ~dm_ready`, where `dm_access_active` is `dm_access` equal to `MEM_READ` or `MEM_WRITE`.
- Reset values: state `IDLE`, `last_data=0`, `drop=0`, bus outputs 0, ready outputs 0, rdata registers 0.
- Asserting `rst_n` low mid-transaction abandons the transaction immediately. Bus-side cleanup is the bus owner's duty.

## Timing
- Request seen in `IDLE` at cycle N: `bus_req` is high at N+1. The earliest `bus_gnt` is N+1.
- `bus_rvalid` is never earlier than the cycle after `bus_gnt`. The earliest is N+2, giving ready at N+3.
- Minimum access latency is 3 cycles. There is one idle cycle between consecutive transactions (the `IDLE` decision cycle).
- A requester must hold its request and address stable until its ready pulse. The ready pulse and the drop of the request may be in the same cycle.
- `flush` and `bus_rvalid` in the same cycle during `I_WAIT`: `drop` wins and no `if_ready` is pulsed.

## Configuration
- `MEM_ARB_PERF_EN` defined adds:
  - 32-bit outputs `perf_stall_f_cnt` and `perf_stall_m_cnt`, counting cycles with `stall_f` and `stall_m` high.
  - Both counters wrap at 2^32 and reset to 0.
- `MEM_ARB_PERF_EN` undefined: the ports and counters are absent. Functional behaviour is identical.

## Structure
- `arb_state_t` (enum of the five states) is added to `riscv_defines`, next to the existing `memaccess_t`.
- No sub-module: a single FSM plus registers.

## Test plan
- Single load: `dm_access=MEM_READ`, `dm_addr=0x100`, bus grants immediately and `rvalid` returns 0xDEADBEEF one cycle later -> `dm_ready` pulses at N+3 with `dm_rdata=0xDEADBEEF`; `stall_m` is high for N..N+2.
- Simultaneous fetch (0x0) and store (0x200, 0x12345678, be=0xF) -> store issued first with `bus_we=1`, then fetch; `if_ready` follows `dm_ready`.
- Back-to-back data requests with `if_req` held -> strict alternation data, fetch, data; `if_ready` fires between the two `dm_ready` pulses.
- `bus_gnt` delayed 4 cycles -> `bus_req` and `bus_addr` stay stable all 4 cycles, and `bus_req` drops the cycle after `bus_gnt`.
- `flush` in `I_WAIT`, `bus_rvalid` the same cycle -> no `if_ready`; the next fetch to 0x40 returns its own data.
- `rst_n` low during `D_WAIT` -> `bus_req`, `dm_ready` and state return to their reset values immediately. A later load completes normally.

Source files
------------

// File: rtl/riscv_defines.sv
// Shared core type definitions: memory access kinds and the memory port
// arbiter state encoding.
// Exports: memaccess_t, arb_state_t and the raw state encodings.
package riscv_defines;

   // Memory-stage access request kind; any value other than read/write is idle.
   typedef enum logic [1:0] {
      MEM_NOACCESS = 2'b00,
      MEM_READ     = 2'b01,
      MEM_WRITE    = 2'b10
   } memaccess_t;

   // Raw arbiter state encodings, kept for tools that only see bit vectors.
   localparam logic [2:0] ARB_IDLE_ENC   = 3'd0;
   localparam logic [2:0] ARB_D_REQ_ENC  = 3'd1;
   localparam logic [2:0] ARB_D_WAIT_ENC = 3'd2;
   localparam logic [2:0] ARB_I_REQ_ENC  = 3'd3;
   localparam logic [2:0] ARB_I_WAIT_ENC = 3'd4;

   // Unified memory port arbiter states.
   typedef enum logic [2:0] {
      IDLE   = ARB_IDLE_ENC,
      D_REQ  = ARB_D_REQ_ENC,
      D_WAIT = ARB_D_WAIT_ENC,
      I_REQ  = ARB_I_REQ_ENC,
      I_WAIT = ARB_I_WAIT_ENC
   } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory bus port between instruction fetch
// and the load/store unit, one outstanding transaction at a time.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   if_req/if_addr/flush            fetch request and redirect
//   if_rdata/if_ready               fetch response (one-cycle pulse)
//   dm_access/dm_addr/dm_wdata/dm_be data request
//   dm_rdata/dm_ready               data response (one-cycle pulse)
//   bus_req/bus_we/bus_addr/bus_wdata/bus_be, bus_gnt  bus request channel
//   bus_rvalid/bus_rdata            bus response channel
//   stall_f, stall_m                pipeline stage holds
// Optional: define MEM_ARB_PERF_EN to add perf_stall_f_cnt/perf_stall_m_cnt
// stall-cycle counters.
module mem_port_arbiter
   import riscv_defines::*;
#(
   parameter  int unsigned ADDR_W = 32,
   parameter  int unsigned DATA_W = 32,
   localparam int unsigned BE_W   = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst_n,
   // instruction fetch side
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              flush,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ready,
   // load/store side
   input  memaccess_t        dm_access,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   input  logic [BE_W-1:0]   dm_be,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_ready,
   // bus side
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   output logic [BE_W-1:0]   bus_be,
   input  logic              bus_gnt,
   input  logic              bus_rvalid,
   input  logic [DATA_W-1:0] bus_rdata,
`ifdef MEM_ARB_PERF_EN
   output logic [31:0]       perf_stall_f_cnt,
   output logic [31:0]       perf_stall_m_cnt,
`endif
   // hazard unit
   output logic              stall_f,
   output logic              stall_m
);

   arb_state_t        state, state_nxt;
   logic              last_data, last_data_nxt;
   logic              drop, drop_nxt;
   logic              bus_req_nxt, bus_we_nxt;
   logic [ADDR_W-1:0] bus_addr_nxt;
   logic [DATA_W-1:0] bus_wdata_nxt;
   logic [BE_W-1:0]   bus_be_nxt;
   logic [DATA_W-1:0] if_rdata_nxt, dm_rdata_nxt;
   logic              if_ready_nxt, dm_ready_nxt;

   logic              dm_active;
   logic              dm_pend;
   logic              if_pend;
   logic              fetch_first;

   // A requester whose ready is pulsing this cycle may still hold its
   // request; it must not be served a second time.
   assign dm_active   = (dm_access == MEM_READ) || (dm_access == MEM_WRITE);
   assign dm_pend     = dm_active & ~dm_ready;
   assign if_pend     = if_req & ~if_ready;
   // Data has priority unless it was served last and fetch is waiting.
   assign fetch_first = if_pend & (~dm_pend | last_data);

   assign stall_f = if_req & ~if_ready;
   assign stall_m = dm_active & ~dm_ready;

   // Next-state and next-output logic.
   always_comb begin
      state_nxt     = state;
      last_data_nxt = last_data;
      drop_nxt      = drop;
      bus_req_nxt   = bus_req;
      bus_we_nxt    = bus_we;
      bus_addr_nxt  = bus_addr;
      bus_wdata_nxt = bus_wdata;
      bus_be_nxt    = bus_be;
      if_rdata_nxt  = if_rdata;
      dm_rdata_nxt  = dm_rdata;
      if_ready_nxt  = 1'b0;
      dm_ready_nxt  = 1'b0;

      case (state)
         IDLE: begin
            drop_nxt = 1'b0;
            if (fetch_first) begin
               state_nxt     = I_REQ;
               bus_req_nxt   = 1'b1;
               bus_we_nxt    = 1'b0;
               bus_addr_nxt  = if_addr;
               bus_wdata_nxt = '0;
               bus_be_nxt    = '1;
            end else if (dm_pend) begin
               state_nxt     = D_REQ;
               bus_req_nxt   = 1'b1;
               bus_we_nxt    = (dm_access == MEM_WRITE);
               bus_addr_nxt  = dm_addr;
               bus_wdata_nxt = dm_wdata;
               bus_be_nxt    = dm_be;
            end
         end

         D_REQ: begin
            if (bus_gnt) begin
               state_nxt   = D_WAIT;
               bus_req_nxt = 1'b0;
            end
         end

         D_WAIT: begin
            if (bus_rvalid) begin
               state_nxt     = IDLE;
               dm_rdata_nxt  = bus_rdata;
               dm_ready_nxt  = 1'b1;
               last_data_nxt = 1'b1;
            end
         end

         I_REQ: begin
            if (flush) begin
               drop_nxt = 1'b1;
            end
            if (bus_gnt) begin
               state_nxt   = I_WAIT;
               bus_req_nxt = 1'b0;
            end
         end

         I_WAIT: begin
            if (bus_rvalid) begin
               // A flush arriving with the response still discards it.
               state_nxt     = IDLE;
               if_rdata_nxt  = bus_rdata;
               if_ready_nxt  = ~(drop | flush);
               last_data_nxt = 1'b0;
               drop_nxt      = 1'b0;
            end else if (flush) begin
               drop_nxt = 1'b1;
            end
         end

         default: begin
            state_nxt   = IDLE;
            bus_req_nxt = 1'b0;
            drop_nxt    = 1'b0;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         last_data <= 1'b0;
         drop      <= 1'b0;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         bus_be    <= '0;
         if_rdata  <= '0;
         dm_rdata  <= '0;
         if_ready  <= 1'b0;
         dm_ready  <= 1'b0;
      end else begin
         state     <= state_nxt;
         last_data <= last_data_nxt;
         drop      <= drop_nxt;
         bus_req   <= bus_req_nxt;
         bus_we    <= bus_we_nxt;
         bus_addr  <= bus_addr_nxt;
         bus_wdata <= bus_wdata_nxt;
         bus_be    <= bus_be_nxt;
         if_rdata  <= if_rdata_nxt;
         dm_rdata  <= dm_rdata_nxt;
         if_ready  <= if_ready_nxt;
         dm_ready  <= dm_ready_nxt;
      end
   end

`ifdef MEM_ARB_PERF_EN
   // Stall-cycle counters; free-running, wrap naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall_f_cnt <= 32'd0;
         perf_stall_m_cnt <= 32'd0;
      end else begin
         if (stall_f) begin
            perf_stall_f_cnt <= perf_stall_f_cnt + 32'd1;
         end
         if (stall_m) begin
            perf_stall_m_cnt <= perf_stall_m_cnt + 32'd1;
         end
      end
   end
`endif

endmodule
